// File: rtl/rfir_cfg_pkg.sv
// Shared RFIR configuration encodings: sequencer states, tap-mode codes and tap counts.
// The adrv9009_rsp RFIR imports the same mode encodings.
package rfir_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_LOAD  = 3'd2,
    ST_CHECK = 3'd3,
    ST_RUN   = 3'd4
  } rfir_state_t;

  localparam logic [1:0] MODE_ILLEGAL = 2'b00;
  localparam logic [1:0] MODE_24T     = 2'b01;
  localparam logic [1:0] MODE_48T     = 2'b10;
  localparam logic [1:0] MODE_72T     = 2'b11;

  localparam logic [6:0] TAPS_24 = 7'd24;
  localparam logic [6:0] TAPS_48 = 7'd48;
  localparam logic [6:0] TAPS_72 = 7'd72;

  function automatic logic [6:0] taps_for_mode(input logic [1:0] mode);
    case (mode)
      MODE_24T: return TAPS_24;
      MODE_48T: return TAPS_48;
      MODE_72T: return TAPS_72;
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/rfir_coeff_loader.sv
// RFIR coefficient loader: drains the filter, streams ROM coefficients into the RFIR RAM, then arms it.
// Optional build macro RFIR_CKSUM_EN adds a coefficient-sum check before arming.
module rfir_coeff_loader
  import rfir_cfg_pkg::*;
#(
  parameter int COEFF_W      = 16,
  parameter int ADDR_W       = 7,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic               clk_r,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode_req,
  input  logic [COEFF_W+6:0] exp_sum,
  output logic [ADDR_W-1:0]  src_addr,
  input  logic [COEFF_W-1:0] src_data,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  addr_in,
  output logic [COEFF_W-1:0] coeff_in,
  output logic               en_rfir,
  output logic [1:0]         mode_rfir,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CNT_W = (DRAIN_CYCLES > 72) ? $clog2(DRAIN_CYCLES + 1) : 7;

  rfir_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       mode_q;
  logic [6:0]       taps_q;
  logic [1:0]       mode_rfir_q;
  logic             done_q;
  logic             err_q;

  logic             start_legal;
  logic             start_bad;
  logic             drain_last;
  logic             load_last;
  logic             cksum_ok;
  logic [CNT_W-1:0] taps_ext;

  assign start_legal = start && (mode_req != MODE_ILLEGAL);
  assign start_bad   = start && (mode_req == MODE_ILLEGAL);
  assign taps_ext    = CNT_W'(taps_q);
  assign drain_last  = (cnt == CNT_W'(DRAIN_CYCLES - 1));
  assign load_last   = (cnt == taps_ext);

  always_ff @(posedge clk_r or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      mode_q      <= '0;
      taps_q      <= '0;
      mode_rfir_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_RUN: begin
            // Illegal request leaves the current state (and a running filter) untouched.
            if (start_legal) begin
              mode_q <= mode_req;
              taps_q <= taps_for_mode(mode_req);
              cnt    <= '0;
              state  <= ST_DRAIN;
            end else if (start_bad) begin
              err_q <= 1'b1;
            end
          end
          ST_DRAIN: begin
            if (drain_last) begin
              cnt   <= '0;
              state <= ST_LOAD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_LOAD: begin
            if (load_last) begin
              cnt   <= '0;
              state <= ST_CHECK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_CHECK: begin
            if (cksum_ok) begin
              mode_rfir_q <= mode_q;
              done_q      <= 1'b1;
              state       <= ST_RUN;
            end else begin
              err_q <= 1'b1;
              state <= ST_IDLE;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // ROM address leads the RAM write by one cycle to cover the ROM read latency.
  always_comb begin
    src_addr = '0;
    wr_en    = 1'b0;
    addr_in  = '0;
    coeff_in = '0;
    if (state == ST_LOAD) begin
      if (cnt < taps_ext) src_addr = ADDR_W'(cnt);
      else                src_addr = ADDR_W'(taps_ext - 1'b1);
      if (cnt != '0) begin
        wr_en    = 1'b1;
        addr_in  = ADDR_W'(cnt - 1'b1);
        coeff_in = src_data;
      end
    end
  end

  assign en_rfir   = (state == ST_RUN);
  assign busy      = (state == ST_DRAIN) || (state == ST_LOAD) || (state == ST_CHECK);
  assign mode_rfir = mode_rfir_q;
  assign done      = done_q;
  assign err       = err_q;

`ifdef RFIR_CKSUM_EN
  logic signed [COEFF_W+6:0] acc;

  always_ff @(posedge clk_r or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (state == ST_DRAIN && drain_last) begin
      acc <= '0;
    end else if (wr_en) begin
      acc <= acc + signed'({{7{coeff_in[COEFF_W-1]}}, coeff_in});
    end
  end

  assign cksum_ok = (acc == signed'(exp_sum));
`else
  logic unused_exp_sum;
  assign unused_exp_sum = ^exp_sum;
  assign cksum_ok       = 1'b1;
`endif

endmodule

// File: tb/tb_rfir_coeff_loader.sv
// Directed self-checking bench for rfir_coeff_loader; ROM model holds ROM[k]=k+1.
module tb_rfir_coeff_loader;

  logic        clk_r = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [1:0]  mode_req;
  logic [22:0] exp_sum;
  logic [6:0]  src_addr;
  logic [15:0] src_data;
  logic        wr_en;
  logic [6:0]  addr_in;
  logic [15:0] coeff_in;
  logic        en_rfir;
  logic [1:0]  mode_rfir;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [15:0] rom [0:127];

  always #5 clk_r = ~clk_r;

  always @(posedge clk_r) src_data <= rom[src_addr];

  rfir_coeff_loader #(.COEFF_W(16), .ADDR_W(7), .DRAIN_CYCLES(8)) dut (
    .clk_r(clk_r), .reset(reset), .start(start), .stop(stop), .mode_req(mode_req),
    .exp_sum(exp_sum), .src_addr(src_addr), .src_data(src_data), .wr_en(wr_en),
    .addr_in(addr_in), .coeff_in(coeff_in), .en_rfir(en_rfir), .mode_rfir(mode_rfir),
    .busy(busy), .done(done), .err(err)
  );

  // Stimulus helper: issues start at the current negedge, then observes until done or budget expiry.
  task automatic run_load(input logic [1:0] m, input int max_cyc, output int done_cyc,
                          output int nwr, output int first_wr, output int bad_wr,
                          output int overlap, output int en_low_pre, output logic en_c1);
    int taps;
    taps = (m == 2'b01) ? 24 : (m == 2'b10) ? 48 : 72;
    exp_sum = 23'(taps * (taps + 1) / 2);
    done_cyc = -1; nwr = 0; first_wr = -1; bad_wr = 0; overlap = 0; en_low_pre = 0; en_c1 = 1'bx;
    mode_req = m;
    start = 1'b1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk_r);
      if (i == 1) begin
        start = 1'b0;
        en_c1 = en_rfir;
      end
      if (wr_en && en_rfir) overlap++;
      if (wr_en) begin
        if (first_wr < 0) first_wr = i;
        if (addr_in != 7'(nwr) || coeff_in != 16'(nwr + 1)) bad_wr++;
        nwr++;
      end
      if (first_wr < 0 && !en_rfir) en_low_pre++;
      if (done) begin
        done_cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode_req = 2'b00; exp_sum = '0;
    repeat (3) @(negedge clk_r);
    checks++;
    if ({wr_en, addr_in, coeff_in, src_addr, en_rfir, mode_rfir, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wr=%b addr=%0d coeff=%0d src=%0d en=%b mode=%b busy=%b done=%b err=%b want all 0",
               wr_en, addr_in, coeff_in, src_addr, en_rfir, mode_rfir, busy, done, err);
    end
    reset = 1'b0;
    @(negedge clk_r);
    checks++;
    if (busy !== 1'b0 || en_rfir !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b en=%b want 0 0", busy, en_rfir);
    end
  endtask

  task automatic test_load24();
    int dc, nw, fw, bw, ov, el;
    logic e1;
    run_load(2'b01, 80, dc, nw, fw, bw, ov, el, e1);
    checks++; if (dc !== 35) begin errors++; $display("FAIL load24_done_cycle: got %0d want 35", dc); end
    checks++; if (nw !== 24) begin errors++; $display("FAIL load24_writes: got %0d want 24", nw); end
    checks++; if (fw !== 10) begin errors++; $display("FAIL load24_first_wr: got %0d want 10", fw); end
    checks++; if (bw !== 0) begin errors++; $display("FAIL load24_addr_data: got %0d bad writes want 0", bw); end
    checks++; if (ov !== 0) begin errors++; $display("FAIL load24_wr_en_overlap: got %0d want 0", ov); end
    checks++; if (el < 8) begin errors++; $display("FAIL load24_drain: got %0d low cycles want >=8", el); end
    checks++;
    if (en_rfir !== 1'b1 || mode_rfir !== 2'b01 || busy !== 1'b0) begin
      errors++;
      $display("FAIL load24_run: got en=%b mode=%b busy=%b want 1 01 0", en_rfir, mode_rfir, busy);
    end
    @(negedge clk_r);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL load24_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_illegal_in_run();
    mode_req = 2'b00; start = 1'b1;
    @(negedge clk_r);
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || en_rfir !== 1'b1 || busy !== 1'b0 || mode_rfir !== 2'b01) begin
      errors++;
      $display("FAIL run_illegal: got err=%b en=%b busy=%b mode=%b want 1 1 0 01", err, en_rfir, busy, mode_rfir);
    end
    @(negedge clk_r);
    checks++;
    if (err !== 1'b0 || en_rfir !== 1'b1) begin
      errors++;
      $display("FAIL run_illegal_after: got err=%b en=%b want 0 1", err, en_rfir);
    end
  endtask

  task automatic test_remode48();
    int dc, nw, fw, bw, ov, el;
    logic e1;
    run_load(2'b10, 100, dc, nw, fw, bw, ov, el, e1);
    checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL remode_en_fall: got %b want 0", e1); end
    checks++; if (dc !== 59) begin errors++; $display("FAIL remode_done_cycle: got %0d want 59", dc); end
    checks++; if (nw !== 48) begin errors++; $display("FAIL remode_writes: got %0d want 48", nw); end
    checks++; if (fw !== 10) begin errors++; $display("FAIL remode_first_wr: got %0d want 10", fw); end
    checks++; if (bw !== 0) begin errors++; $display("FAIL remode_addr_data: got %0d bad writes want 0", bw); end
    checks++; if (ov !== 0) begin errors++; $display("FAIL remode_overlap: got %0d want 0", ov); end
    checks++; if (el !== 9) begin errors++; $display("FAIL remode_en_low: got %0d want 9", el); end
    checks++;
    if (en_rfir !== 1'b1 || mode_rfir !== 2'b10) begin
      errors++;
      $display("FAIL remode_run: got en=%b mode=%b want 1 10", en_rfir, mode_rfir);
    end
  endtask

  task automatic test_illegal_in_idle();
    stop = 1'b1;
    @(negedge clk_r);
    stop = 1'b0;
    checks++;
    if (en_rfir !== 1'b0 || mode_rfir !== 2'b10) begin
      errors++;
      $display("FAIL stop_run: got en=%b mode=%b want 0 10", en_rfir, mode_rfir);
    end
    mode_req = 2'b00; start = 1'b1;
    @(negedge clk_r);
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0 || en_rfir !== 1'b0) begin
      errors++;
      $display("FAIL idle_illegal: got err=%b wr=%b busy=%b en=%b want 1 0 0 0", err, wr_en, busy, en_rfir);
    end
    @(negedge clk_r);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_illegal_after: got err=%b busy=%b want 0 0", err, busy);
    end
  endtask

  task automatic test_stop_midload();
    int seen_done = 0;
    int seen_wr = 0;
    mode_req = 2'b11; exp_sum = 23'd2628; start = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk_r);
      if (i == 1) start = 1'b0;
    end
    checks++;
    if (wr_en !== 1'b1 || addr_in !== 7'd9 || coeff_in !== 16'd10) begin
      errors++;
      $display("FAIL stop_pre: got wr=%b addr=%0d coeff=%0d want 1 9 10", wr_en, addr_in, coeff_in);
    end
    stop = 1'b1;
    @(negedge clk_r);
    stop = 1'b0;
    checks++;
    if (wr_en !== 1'b0 || en_rfir !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_post: got wr=%b en=%b busy=%b want 0 0 0", wr_en, en_rfir, busy);
    end
    repeat (70) begin
      @(negedge clk_r);
      if (done) seen_done++;
      if (wr_en) seen_wr++;
    end
    checks++;
    if (seen_done !== 0 || seen_wr !== 0) begin
      errors++;
      $display("FAIL stop_aborted: got done=%0d wr=%0d want 0 0", seen_done, seen_wr);
    end
  endtask

  task automatic test_async_reset();
    int dc, nw, fw, bw, ov, el;
    logic e1;
    mode_req = 2'b01; exp_sum = 23'd300; start = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk_r);
      if (i == 1) start = 1'b0;
    end
    checks++;
    if (wr_en !== 1'b1 || addr_in !== 7'd5) begin
      errors++;
      $display("FAIL areset_pre: got wr=%b addr=%0d want 1 5", wr_en, addr_in);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (wr_en !== 1'b0 || addr_in !== 7'd0 || en_rfir !== 1'b0 || busy !== 1'b0 || src_addr !== 7'd0) begin
      errors++;
      $display("FAIL areset_async: got wr=%b addr=%0d en=%b busy=%b src=%0d want 0 0 0 0 0",
               wr_en, addr_in, en_rfir, busy, src_addr);
    end
    @(negedge clk_r);
    reset = 1'b0;
    @(negedge clk_r);
    checks++;
    if (busy !== 1'b0 || en_rfir !== 1'b0 || mode_rfir !== 2'b00) begin
      errors++;
      $display("FAIL areset_idle: got busy=%b en=%b mode=%b want 0 0 00", busy, en_rfir, mode_rfir);
    end
    run_load(2'b01, 80, dc, nw, fw, bw, ov, el, e1);
    checks++;
    if (dc !== 35 || nw !== 24 || bw !== 0) begin
      errors++;
      $display("FAIL areset_reload: got done=%0d writes=%0d bad=%0d want 35 24 0", dc, nw, bw);
    end
  endtask

`ifdef RFIR_CKSUM_EN
  task automatic test_cksum();
    int seen_done = 0;
    int err_cyc = -1;
    stop = 1'b1;
    @(negedge clk_r);
    stop = 1'b0;
    mode_req = 2'b01; exp_sum = 23'd301; start = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk_r);
      if (i == 1) start = 1'b0;
      if (done) seen_done++;
      if (err && err_cyc < 0) err_cyc = i;
    end
    checks++;
    if (err_cyc !== 35 || seen_done !== 0) begin
      errors++;
      $display("FAIL cksum_mismatch: got err_cycle=%0d done=%0d want 35 0", err_cyc, seen_done);
    end
    checks++;
    if (en_rfir !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cksum_idle: got en=%b busy=%b want 0 0", en_rfir, busy);
    end
  endtask
`endif

  initial begin
    for (int k = 0; k < 128; k++) rom[k] = 16'(k + 1);
    test_reset();
    test_load24();
    test_illegal_in_run();
    test_remode48();
    test_illegal_in_idle();
    test_stop_midload();
    test_async_reset();
`ifdef RFIR_CKSUM_EN
    test_cksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
